// File: rtl/bp_pkg.sv
// bp_pkg: shared constants and helpers for the pattern-history-table predictor
package bp_pkg;
  localparam int IDX_W_DEF = 6;
  localparam int CTR_W_DEF = 2;
  localparam int PC_OFS = 2;
  typedef enum logic {NOT_TAKEN = 1'b0, TAKEN = 1'b1} dir_e;
  function automatic int ctr_max(input int w);
    return (1 << w) - 1;
  endfunction
endpackage

// File: rtl/bp_sat_counter.sv
// bp_sat_counter: one saturating direction counter with MSB prediction and strong flag
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int CTR_W = CTR_W_DEF,
  parameter logic [CTR_W-1:0] CTR_INIT = '0
) (
  input  logic i_clock,
  input  logic i_init,
  input  logic i_en,
  input  logic i_outcome,
  output logic o_pred,
  output logic o_strong
);
  localparam logic [CTR_W-1:0] MAX = CTR_W'(ctr_max(CTR_W));
  logic [CTR_W-1:0] r_ctr;
  always_ff @(posedge i_clock)
    if (i_init) r_ctr <= CTR_INIT;
    else if (i_en)
      r_ctr <= (i_outcome == TAKEN) ? ((r_ctr == MAX) ? r_ctr : r_ctr + CTR_W'(1))
                                    : ((r_ctr == '0) ? r_ctr : r_ctr - CTR_W'(1));
  assign o_pred = r_ctr[CTR_W-1];
  assign o_strong = (r_ctr == MAX) || (r_ctr == '0);
endmodule

// File: rtl/branch_pht.sv
// branch_pht: PHT branch predictor with miss counter; gshare indexing when BRANCH_PHT_GSHARE_EN is defined
module branch_pht
  import bp_pkg::*;
#(
  parameter int PC_W = 32,
  parameter int IDX_W = IDX_W_DEF,
  parameter int CTR_W = CTR_W_DEF,
  parameter int CTR_INIT = 0,
  parameter int MISS_W = 16
) (
  input  logic              i_clock,
  input  logic              i_init,
  input  logic [PC_W-1:0]   i_lookup_pc,
  output logic              o_prediction,
  output logic              o_pred_strong,
  output logic [IDX_W-1:0]  o_pred_idx,
  input  logic              i_upd_en,
  input  logic [IDX_W-1:0]  i_upd_idx,
  input  logic              i_upd_outcome,
  input  logic              i_upd_pred,
  output logic [MISS_W-1:0] o_miss_count
);
  localparam int N = 1 << IDX_W;
  logic [N-1:0] w_pred, w_strong;
  logic [IDX_W-1:0] w_pc_idx;
  logic [MISS_W-1:0] r_miss;
  logic w_unused;
  assign w_pc_idx = i_lookup_pc[IDX_W+PC_OFS-1:PC_OFS];
  assign w_unused = ^{i_lookup_pc[PC_W-1:IDX_W+PC_OFS], i_lookup_pc[PC_OFS-1:0]};
  for (genvar g = 0; g < N; g++) begin : g_ctr
    bp_sat_counter #(.CTR_W(CTR_W), .CTR_INIT(CTR_W'(CTR_INIT))) u_ctr (
      .i_clock  (i_clock),
      .i_init   (i_init),
      .i_en     (i_upd_en && (i_upd_idx == IDX_W'(g))),
      .i_outcome(i_upd_outcome),
      .o_pred   (w_pred[g]),
      .o_strong (w_strong[g])
    );
  end
`ifdef BRANCH_PHT_GSHARE_EN
  logic [IDX_W-1:0] r_ghr;
  always_ff @(posedge i_clock)
    if (i_init) r_ghr <= '0;
    else if (i_upd_en) r_ghr <= {r_ghr[IDX_W-2:0], i_upd_outcome};
  assign o_pred_idx = w_pc_idx ^ r_ghr;
`else
  assign o_pred_idx = w_pc_idx;
`endif
  // lookup reads the registered table, so a same-cycle update shows up only next cycle
  assign o_prediction = w_pred[o_pred_idx];
  assign o_pred_strong = w_strong[o_pred_idx];
  always_ff @(posedge i_clock)
    if (i_init) r_miss <= '0;
    else if (i_upd_en && (i_upd_outcome != i_upd_pred) && !(&r_miss)) r_miss <= r_miss + MISS_W'(1);
  assign o_miss_count = r_miss;
endmodule

// File: doc/branch_pht.md
Name: branch_pht

Overview:
- Parametrised pattern-history-table branch predictor for the RV32IM pipeline; successor to the single 2-bit saturating counter.
- Holds 2^IDX_W independent CTR_W-bit saturating counters indexed by PC bits; IF stage looks up, EX stage trains.
- Adds index handoff, strong/weak confidence and a misprediction statistics counter.

Parameters:
- PC_W, 32, program counter width.
- IDX_W, 6, table index width; entries = 2^IDX_W.
- CTR_W, 2, counter width (>=2).
- CTR_INIT, 0, reset value of every counter (0 = strongly not-taken).
- MISS_W, 16, width of misprediction counter.

Ports:
- CLOCK  in  1  clock, all state on rising edge.
- INIT  in  1  synchronous active-high reset.
- LOOKUP_PC  in  PC_W  PC of fetched instruction.
- PREDICTION  out  1  predicted direction (1 = taken).
- PRED_STRONG  out  1  selected counter is saturated (0 or max).
- PRED_IDX  out  IDX_W  index used for this lookup; carried down the pipe.
- UPD_EN  in  1  resolved branch update strobe.
- UPD_IDX  in  IDX_W  index returned from PRED_IDX at fetch.
- UPD_OUTCOME  in  1  actual direction.
- UPD_PRED  in  1  direction that was predicted for this branch.
- MISS_COUNT  out  MISS_W  number of mispredictions since reset.

Behaviour:
- Clock CLOCK; reset INIT is synchronous, active-high.
- Lookup is combinational, zero latency: PRED_IDX = LOOKUP_PC[IDX_W+1:2]; PREDICTION = MSB of ctr[PRED_IDX]; PRED_STRONG = ctr is all-0s or all-1s.
- Update on posedge when UPD_EN=1: outcome 1 -> ctr[UPD_IDX]+1 unless at 2^CTR_W-1; outcome 0 -> ctr-1 unless 0. Saturate, never wrap. Only one entry changes per cycle.
- UPD_EN=0: table unchanged.
- Same-cycle lookup and update to same index: PREDICTION shows pre-update value; new value visible next cycle. No bypass.
- MISS_COUNT: increments on posedge when UPD_EN=1 and UPD_OUTCOME != UPD_PRED; saturates at 2^MISS_W-1.
- INIT=1: all counters <= CTR_INIT, MISS_COUNT <= 0. INIT takes priority over a concurrent UPD_EN; that update is dropped.
- After reset, combinational outputs follow: PREDICTION = MSB of CTR_INIT, PRED_STRONG = 1 for default CTR_INIT=0, PRED_IDX tracks LOOKUP_PC.
- No internal FSM beyond per-entry counter state.
- Each counter walks 0 -> 1 -> ... -> max on taken and reverses on not-taken.

Optional Feature:
- Macro BRANCH_PHT_GSHARE_EN.
- Defined: add an IDX_W-bit global history register GHR, reset to 0. PRED_IDX = LOOKUP_PC[IDX_W+1:2] XOR GHR. On UPD_EN, GHR <= {GHR[IDX_W-2:0], UPD_OUTCOME}, updated alongside the counter; INIT clears it.
- Training always uses UPD_IDX, so indexing is consistent with the fetch-time history.
- Not defined: no GHR; pure PC indexing as above.

Decomposition:
- Package bp_pkg: IDX_W/CTR_W defaults, taken/not-taken encodings, ctr_max function, PC index offset constant (2).
- Sub-module bp_sat_counter: one CTR_W-bit saturating counter with INIT, ENABLE and OUTCOME inputs, MSB prediction and strong outputs.
- branch_pht instantiates 2^IDX_W copies via generate, decodes UPD_IDX to per-counter enables, and muxes the lookup.

Test Plan:
- Reset then LOOKUP_PC=0x40 -> PREDICTION=0, PRED_STRONG=1, PRED_IDX=0x10, MISS_COUNT=0.
- Three updates UPD_IDX=0x10, outcome=1 -> prediction goes 0,0(after 1st),1(after 2nd), strong after 3rd; 4th taken leaves ctr=3. Four not-taken return to 0 and saturate.
- Same-cycle LOOKUP_PC=0x40 and update idx 0x10 taken, ctr=1 -> PREDICTION=0 that cycle, 1 next cycle; idx 0x11 unchanged.
- UPD_EN with UPD_PRED=1, UPD_OUTCOME=0, repeated 5 times -> MISS_COUNT=5; MISS_W=2 build saturates at 3.
- INIT asserted together with UPD_EN mid-training -> all counters CTR_INIT, MISS_COUNT=0, update ignored.
- BRANCH_PHT_GSHARE_EN: after taken updates 1,1, GHR=0b11 and LOOKUP_PC=0x40 gives PRED_IDX=0x13; without macro PRED_IDX=0x10.
